// File: rtl/audio_mix_out_adapter.sv
// Mixes NUM_VOICES signed samples with saturation and attenuation, queues frames, and feeds Audio_Controller.
// Optional: AUDIO_UNDERRUN_HOLD_EN keeps the write strobe up on underrun, repeating the last sample.
module audio_mix_out_adapter #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 24,
  parameter int DEPTH      = 8
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [3:0]                     volume,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           audio_out_allowed,
  output logic                           write_audio_out,
  output logic [31:0]                    left_channel_audio_out,
  output logic [31:0]                    right_channel_audio_out,
  output logic [$clog2(DEPTH):0]         fifo_level,
  output logic                           sat_flag,
  output logic                           underrun
);
  localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [NUM_VOICES-1:0][SUM_W-1:0] w_lane;
  logic [SUM_W-1:0]                 w_sum;
  logic signed [SUM_W-1:0]          w_shift;
  logic                             w_hi, w_lo;
  logic [SAMPLE_W-1:0]              w_sat_val;
  logic                             w_accept, w_push, w_pop, w_empty;
  logic [LW:0]                      w_occ;
  logic [SAMPLE_W-1:0]              w_head;
  logic [31:0]                      w_word;

  logic [1:0]                       r_vld_pipe;  // [0] = stage 1, [1] = stage 2
  logic signed [SUM_W-1:0]          r_s1_sum;
  logic [3:0]                       r_s1_vol;
  logic [SAMPLE_W-1:0]              r_s2_data;
  logic [SAMPLE_W-1:0]              r_mem [DEPTH];
  logic [AW-1:0]                    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]                    r_level;
  logic [SAMPLE_W-1:0]              r_last;
  logic                             r_sat, r_underrun;

  // Per-lane enable mask and sign extension to the full sum width
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_lane
    assign w_lane[g] = voice_en[g]
      ? {{(SUM_W-SAMPLE_W){voice_data[g*SAMPLE_W+SAMPLE_W-1]}}, voice_data[g*SAMPLE_W +: SAMPLE_W]}
      : '0;
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) w_sum = w_sum + w_lane[i];
  end

  assign w_shift   = r_s1_sum >>> r_s1_vol;
  assign w_hi      = w_shift > SAT_MAX;
  assign w_lo      = w_shift < SAT_MIN;
  assign w_sat_val = w_hi ? {1'b0, {(SAMPLE_W-1){1'b1}}} :
                     w_lo ? {1'b1, {(SAMPLE_W-1){1'b0}}} : w_shift[SAMPLE_W-1:0];

  // Occupancy counts frames still in the pipeline so a push never meets a full FIFO
  assign w_occ    = {1'b0, r_level} + (LW+1)'(r_vld_pipe[0]) + (LW+1)'(r_vld_pipe[1]);
  assign in_ready = !reset && (w_occ < (LW+1)'(DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_empty  = (r_level == '0);
  assign w_push   = r_vld_pipe[1];
  assign w_pop    = audio_out_allowed && !w_empty;

`ifdef AUDIO_UNDERRUN_HOLD_EN
  assign write_audio_out = audio_out_allowed && !reset;
`else
  assign write_audio_out = w_pop;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_s1_sum   <= '0;
      r_s1_vol   <= '0;
      r_s2_data  <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_accept};
      if (w_accept) begin
        r_s1_sum <= w_sum;
        r_s1_vol <= volume;
      end
      if (r_vld_pipe[0]) begin
        r_s2_data <= w_sat_val;
        if (w_hi || w_lo) r_sat <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s2_data;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_last     <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (audio_out_allowed && w_empty) r_underrun <= 1'b1;
    end
  end

  // Show-ahead head; once drained the last popped sample stays on the bus
  assign w_head = w_empty ? r_last : r_mem[r_rd_ptr];
  assign w_word = 32'(w_head) << (32 - SAMPLE_W);

  assign left_channel_audio_out  = w_word;
  assign right_channel_audio_out = w_word;
  assign fifo_level              = r_level;
  assign sat_flag                = r_sat;
  assign underrun                = r_underrun;
endmodule

// File: tb/tb_audio_mix_out_adapter.sv
// Bench for audio_mix_out_adapter: vector table, scripted corner cases and a random scoreboard.
module tb_audio_mix_out_adapter;
  localparam int NV = 4, SW = 24, DEPTH = 8;
`ifdef AUDIO_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic [95:0]   voice_data = '0;
  logic [3:0]    voice_en = '0, volume = '0;
  logic          in_valid = 1'b0, in_ready;
  logic          audio_out_allowed = 1'b0, write_audio_out;
  logic [31:0]   left_o, right_o;
  logic [3:0]    fifo_level;
  logic          sat_flag, underrun;

  audio_mix_out_adapter #(.NUM_VOICES(NV), .SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .voice_data(voice_data), .voice_en(voice_en),
    .volume(volume), .in_valid(in_valid), .in_ready(in_ready),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_o), .right_channel_audio_out(right_o),
    .fifo_level(fifo_level), .sat_flag(sat_flag), .underrun(underrun));

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames accepted but not yet written, tagged with accept sample index
  typedef struct { int acc; logic [31:0] word; bit sat; } ent_t;
  ent_t        q[$];
  logic [31:0] m_last = '0;
  bit          m_sat = 0, m_under = 0;
  int          samp = 0;
  logic        obs_write, obs_ready, obs_sat, obs_under;
  logic [31:0] obs_left, obs_right;
  logic [3:0]  obs_level;

  function automatic logic [31:0] ref_word(input logic [95:0] d, input logic [3:0] en,
                                           input logic [3:0] vol, output bit sat);
    longint s = 0;
    logic [23:0] v, t;
    for (int i = 0; i < 4; i++) begin
      v = d[i*24 +: 24];
      if (en[i]) s += longint'($signed(v));
    end
    s = s >>> vol;
    sat = 0;
    if (s > 64'sd8388607) begin s = 64'sd8388607; sat = 1; end
    else if (s < -64'sd8388608) begin s = -64'sd8388608; sat = 1; end
    t = s[23:0];
    return {t, 8'h00};
  endfunction

  function automatic logic [95:0] pack4(input int a, input int b, input int c, input int d);
    logic [23:0] x0, x1, x2, x3;
    x0 = a[23:0]; x1 = b[23:0]; x2 = c[23:0]; x3 = d[23:0];
    return {x3, x2, x1, x0};
  endfunction

  task automatic model_reset();
    q.delete(); m_last = '0; m_sat = 0; m_under = 0;
  endtask

  // One cycle: sample at negedge, compare with model, advance model, return at posedge+1
  task automatic step();
    int vis;
    bit e_ready, e_write, s;
    logic [31:0] e_word, w;
    @(negedge CLOCK_50);
    vis = 0;
    foreach (q[i]) begin
      if (q[i].acc + 3 <= samp) vis++;
      if (q[i].sat && q[i].acc + 2 <= samp) m_sat = 1;
    end
    e_ready = q.size() < DEPTH;
    e_write = audio_out_allowed && (vis > 0 || HOLD);
    e_word  = (vis > 0) ? q[0].word : m_last;
    obs_write = write_audio_out; obs_ready = in_ready; obs_left = left_o; obs_right = right_o;
    obs_level = fifo_level; obs_sat = sat_flag; obs_under = underrun;
    chk("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
    chk("write", {31'b0, write_audio_out}, {31'b0, e_write});
    chk("left", left_o, e_word);
    chk("right", right_o, e_word);
    chk("fifo_level", {28'b0, fifo_level}, 32'(vis));
    chk("sat_flag", {31'b0, sat_flag}, {31'b0, m_sat});
    chk("underrun", {31'b0, underrun}, {31'b0, m_under});
    if (audio_out_allowed && vis == 0) m_under = 1;
    if (audio_out_allowed && vis > 0) begin m_last = q[0].word; void'(q.pop_front()); end
    if (in_valid && e_ready) begin
      w = ref_word(voice_data, voice_en, volume, s);
      q.push_back('{samp, w, s});
    end
    samp++;
    @(posedge CLOCK_50); #1;
  endtask

  typedef struct { logic [95:0] d; logic [3:0] en; logic [3:0] vol; logic [31:0] exp; } vec_t;
  vec_t vt[6];

  initial begin
    int ins, outs;
    vt[0] = '{pack4(100, 200, -50, 7), 4'b1011, 4'd0, 32'h00013300};
    vt[1] = '{pack4(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF), 4'b1111, 4'd0, 32'h7FFFFF00};
    vt[2] = '{pack4(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF), 4'b1111, 4'd2, 32'h7FFFFF00};
    vt[3] = '{pack4(32'h800000, 32'h800000, 32'h800000, 32'h800000), 4'b1111, 4'd0, 32'h80000000};
    vt[4] = '{pack4(-1000, 5, 5, 5), 4'b0001, 4'd4, 32'hFFFFC100};
    vt[5] = '{pack4(1, 2, 3, 4), 4'b0000, 4'd0, 32'h00000000};

    // Reset state
    audio_out_allowed = 1'b1;
    #23;
    chk("rst_write", {31'b0, write_audio_out}, 32'd0);
    chk("rst_level", {28'b0, fifo_level}, 32'd0);
    chk("rst_left", left_o, 32'd0);
    chk("rst_sat", {31'b0, sat_flag}, 32'd0);
    chk("rst_under", {31'b0, underrun}, 32'd0);
    @(posedge CLOCK_50); #1; reset = 1'b0;
    step();
    chk("rel_ready", {31'b0, obs_ready}, 32'd1);

    // Table vectors: single frame, 3-cycle latency to write strobe
    foreach (vt[k]) begin
      voice_data = vt[k].d; voice_en = vt[k].en; volume = vt[k].vol; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      chk($sformatf("vec%0d_write", k), {31'b0, obs_write}, 32'd1);
      chk($sformatf("vec%0d_left", k), obs_left, vt[k].exp);
      chk($sformatf("vec%0d_right", k), obs_right, vt[k].exp);
      step();
    end
    chk("sat_sticky", {31'b0, obs_sat}, 32'd1);

    // Backpressure: exactly DEPTH frames admitted while the controller refuses
    audio_out_allowed = 1'b0; ins = 0;
    for (int i = 0; i < 20; i++) begin
      voice_data = {$urandom(), $urandom(), $urandom()}; voice_en = 4'($urandom()); volume = 4'($urandom());
      in_valid = 1'b1;
      step();
      if (obs_ready) ins++;
    end
    in_valid = 1'b0;
    chk("bp_accepts", ins, 32'd8);
    chk("bp_ready", {31'b0, obs_ready}, 32'd0);
    chk("bp_level", {28'b0, obs_level}, 32'd8);
    audio_out_allowed = 1'b1; outs = 0;
    for (int i = 0; i < 12; i++) begin step(); if (obs_write && obs_level != 0) outs++; end
    chk("bp_writes", outs, 32'd8);
    chk("drain_write", {31'b0, obs_write}, {31'b0, HOLD});
    chk("drain_level", {28'b0, obs_level}, 32'd0);
    chk("drain_under", {31'b0, obs_under}, 32'd1);

    // Streaming: 100 frames in, 100 frames out, in order
    ins = 0; outs = 0;
    for (int i = 0; i < 200 && ins < 100; i++) begin
      voice_data = {$urandom(), $urandom(), $urandom()}; voice_en = 4'($urandom()); volume = 4'($urandom());
      in_valid = 1'b1;
      step();
      if (obs_ready) ins++;
      if (obs_write && obs_level != 0) outs++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin step(); if (obs_write && obs_level != 0) outs++; end
    chk("stream_in", ins, 32'd100);
    chk("stream_out", outs, 32'd100);

    // Random valid/allowed mix
    for (int i = 0; i < 300; i++) begin
      voice_data = {$urandom(), $urandom(), $urandom()}; voice_en = 4'($urandom()); volume = 4'($urandom());
      in_valid = 1'($urandom()); audio_out_allowed = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; audio_out_allowed = 1'b1;
    repeat (15) step();

    // Reset mid-operation: 5 queued, one in stage 1
    audio_out_allowed = 1'b0; in_valid = 1'b1; voice_en = 4'hF; volume = 4'd0;
    for (int i = 0; i < 5; i++) begin voice_data = pack4(i + 1, 0, 0, 0); step(); end
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_level", {28'b0, obs_level}, 32'd5);
    voice_data = pack4(32'h7FFFFF, 32'h7FFFFF, 0, 0); in_valid = 1'b1;
    step();
    in_valid = 1'b0; audio_out_allowed = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_write", {31'b0, write_audio_out}, 32'd0);
    chk("mid_rst_level", {28'b0, fifo_level}, 32'd0);
    chk("mid_rst_left", left_o, 32'd0);
    chk("mid_rst_right", right_o, 32'd0);
    chk("mid_rst_sat", {31'b0, sat_flag}, 32'd0);
    chk("mid_rst_under", {31'b0, underrun}, 32'd0);
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1; reset = 1'b0;
    step();
    chk("post_rst_ready", {31'b0, obs_ready}, 32'd1);
    repeat (6) step();
    chk("post_rst_level", {28'b0, obs_level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
